// File: rtl/myproject_mac_pkg.sv
// myproject_mac_pkg: shared FSM state, product width and saturating add for the MAC lanes
package myproject_mac_pkg;

    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

    typedef struct packed {
        logic              ovf;
        logic signed [63:0] val;
    } sat_t;

    function automatic int prod_w(input int d0_w, input int d1_w);
        return d0_w + d1_w + 1;
    endfunction

    function automatic sat_t sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        logic signed [63:0] s, hi, lo;
        sat_t r;
        s = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.ovf = (s > hi) || (s < lo);
        r.val = (s > hi) ? hi : (s < lo) ? lo : s;
        return r;
    endfunction

endpackage

// File: rtl/myproject_mac_lane.sv
// myproject_mac_lane: operand extension, product pipeline and saturating accumulator for one lane
module myproject_mac_lane
    import myproject_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 9,
    parameter int DIN1_WIDTH = 12,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        din0_signed,
    input  logic                        acc_en,
    input  logic                        clr,
    input  logic [DIN0_WIDTH-1:0]       din0,
    input  logic [DIN1_WIDTH-1:0]       din1,
    output logic signed [ACC_WIDTH-1:0] acc,
    output logic                        sat
);
    localparam int PW = prod_w(DIN0_WIDTH, DIN1_WIDTH);

    logic signed [DIN0_WIDTH:0]   op0;
    logic signed [DIN1_WIDTH-1:0] op1;
    logic signed [PW-1:0]         prod, pout;
    logic signed [ACC_WIDTH-1:0]  acc_nxt;
    sat_t                         r;

    assign op0 = {din0_signed & din0[DIN0_WIDTH-1], din0};
    assign op1 = din1;
    assign prod = PW'(op0) * PW'(op1);

    generate
        if (NUM_STAGE == 0) begin : g_comb
            assign pout = prod;
        end else begin : g_pipe
            logic signed [PW-1:0] q [NUM_STAGE];
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    for (int i = 0; i < NUM_STAGE; i++) q[i] <= '0;
                end else begin
                    q[0] <= prod;
                    for (int i = 1; i < NUM_STAGE; i++) q[i] <= q[i-1];
                end
            assign pout = q[NUM_STAGE-1];
        end
    endgenerate

    assign r = sat_add(64'(acc), 64'(pout), ACC_WIDTH);
    assign acc_nxt = ACC_WIDTH'(r.val);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (acc_en) begin
            acc <= acc_nxt;
            sat <= sat | r.ovf;
        end

endmodule

// File: rtl/myproject_mac_lanes.sv
// myproject_mac_lanes: multi-lane pipelined saturating MAC with term counting and valid/ready handshakes
module myproject_mac_lanes
    import myproject_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 9,
    parameter int DIN1_WIDTH = 12,
    parameter int LANES      = 4,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_WIDTH  = 24,
    parameter int N_TERMS    = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        din0_signed,
    input  logic [LANES*DIN0_WIDTH-1:0] din0,
    input  logic [LANES*DIN1_WIDTH-1:0] din1,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*ACC_WIDTH-1:0]  out_data,
    output logic [LANES-1:0]            out_sat
);
    localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    dcnt;
    logic          fire, acc_en, clr;

    assign fire = in_valid && in_ready;
    assign clr = out_valid && out_ready;

    generate
        if (NUM_STAGE == 0) begin : g_nv
            assign acc_en = fire;
        end else begin : g_v
            logic [NUM_STAGE-1:0] vr;
            always_ff @(posedge ap_clk or negedge ap_rst_n)
                if (!ap_rst_n) vr <= '0;
                else vr <= NUM_STAGE'({vr, fire});
            assign acc_en = vr[NUM_STAGE-1];
        end
    endgenerate

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            state     <= ACC;
            cnt       <= '0;
            dcnt      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: if (fire) begin
                    if (cnt == CW'(N_TERMS - 1)) begin
                        cnt      <= '0;
                        dcnt     <= '0;
                        in_ready <= 1'b0;
                        if (NUM_STAGE > 0) begin
                            state <= DRAIN;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: if (dcnt == 3'(NUM_STAGE - 1)) begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end else begin
                    dcnt <= dcnt + 3'd1;
                end
                HOLD: if (out_ready) begin
                    state     <= ACC;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
                default: state <= ACC;
            endcase
        end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        myproject_mac_lane #(
            .DIN0_WIDTH(DIN0_WIDTH),
            .DIN1_WIDTH(DIN1_WIDTH),
            .NUM_STAGE (NUM_STAGE),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk        (ap_clk),
            .rst_n      (ap_rst_n),
            .din0_signed(din0_signed),
            .acc_en     (acc_en),
            .clr        (clr),
            .din0       (din0[k*DIN0_WIDTH +: DIN0_WIDTH]),
            .din1       (din1[k*DIN1_WIDTH +: DIN1_WIDTH]),
            .acc        (out_data[k*ACC_WIDTH +: ACC_WIDTH]),
            .sat        (out_sat[k])
        );
    end

endmodule

// File: tb/tb_myproject_mac_lanes.sv
// tb_myproject_mac_lanes: directed and randomized checks against an arithmetic MAC reference model
module tb_myproject_mac_lanes;
    localparam int D0 = 9, D1 = 12, L = 4, NS = 2, AW = 24, NT = 16;
    localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
    localparam longint MINV = -MAXV - 1;

    logic            ap_clk = 0, ap_rst_n = 0, in_valid = 0, din0_signed = 0, out_ready = 0;
    logic            in_ready, out_valid;
    logic [L*D0-1:0] din0 = '0;
    logic [L*D1-1:0] din1 = '0;
    logic [L*AW-1:0] out_data;
    logic [L-1:0]    out_sat;

    int     total = 0, passes = 0, fails = 0;
    longint m_acc [L];
    logic [L-1:0] m_sat;

    always #5 ap_clk = ~ap_clk;

    myproject_mac_lanes #(
        .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .LANES(L), .NUM_STAGE(NS), .ACC_WIDTH(AW), .N_TERMS(NT)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din0_signed(din0_signed), .din0(din0), .din1(din1), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane_out(input int k);
        return longint'($signed(out_data[k*AW +: AW]));
    endfunction

    task automatic model_clear;
        for (int k = 0; k < L; k++) m_acc[k] = 0;
        m_sat = '0;
    endtask

    task automatic model_add(input logic sgn, input logic [L*D0-1:0] a, input logic [L*D1-1:0] b);
        for (int k = 0; k < L; k++) begin
            longint x, y;
            x = longint'(a[k*D0 +: D0]);
            y = longint'(b[k*D1 +: D1]);
            if (sgn && x >= 256) x -= 512;
            if (y >= 2048) y -= 4096;
            m_acc[k] += x * y;
            if (m_acc[k] > MAXV) begin
                m_acc[k] = MAXV;
                m_sat[k] = 1'b1;
            end else if (m_acc[k] < MINV) begin
                m_acc[k] = MINV;
                m_sat[k] = 1'b1;
            end
        end
    endtask

    task automatic send(input logic sgn, input logic [L*D0-1:0] a, input logic [L*D1-1:0] b, input int gap);
        int n;
        repeat (gap) tick;
        din0_signed = sgn;
        din0 = a;
        din1 = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick;
            n++;
        end
        if (n >= 200) chk("in_ready_wait", in_ready, 1);
        tick;
        in_valid = 1'b0;
        din0 = '0;
        din1 = '0;
        model_add(sgn, a, b);
    endtask

    task automatic run_group(input int mode, input int gap_max);
        for (int i = 0; i < NT; i++) begin
            logic s;
            s = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
            send(s, (L*D0)'({$urandom, $urandom}), (L*D1)'({$urandom, $urandom}), $urandom_range(0, gap_max));
        end
    endtask

    task automatic wait_valid(input string tag, input int lat_exp);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            tick;
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        if (lat_exp >= 0) chk({tag, "_lat"}, n, lat_exp);
    endtask

    task automatic take_result(input string tag);
        for (int k = 0; k < L; k++) begin
            chk($sformatf("%s_data%0d", tag, k), lane_out(k), m_acc[k]);
            chk($sformatf("%s_sat%0d", tag, k), out_sat[k], m_sat[k]);
        end
        chk({tag, "_busy"}, in_ready, 0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, "_rdy_back"}, in_ready, 1);
        chk({tag, "_vld_drop"}, out_valid, 0);
        model_clear;
    endtask

    initial begin
        model_clear;
        repeat (3) tick;
        ap_rst_n = 1'b1;
        tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", longint'(out_data == '0), 1);
        chk("rst_out_sat", out_sat, 0);

        for (int i = 0; i < NT; i++) send(1'b0, {L{9'd3}}, {L{12'hFFE}}, 0);
        wait_valid("basic", 2);
        chk("basic_model", m_acc[0], -96);
        take_result("basic");

        for (int i = 0; i < NT; i++) send(1'b0, {L{9'h1FF}}, {L{12'd1}}, 0);
        wait_valid("mode_u", -1);
        chk("mode_u_model", m_acc[0], 8176);
        take_result("mode_u");
        for (int i = 0; i < NT; i++) send(1'b1, {L{9'h1FF}}, {L{12'd1}}, 0);
        wait_valid("mode_s", -1);
        chk("mode_s_model", m_acc[0], -16);
        take_result("mode_s");

        for (int i = 0; i < NT; i++) send(1'b0, {L{9'd511}}, {12'd2047, 12'd1, 12'h800, 12'd2047}, 0);
        wait_valid("sat", -1);
        chk("sat_model", m_acc[0], MAXV);
        take_result("sat");
        for (int i = 0; i < NT; i++) send(1'b0, {L{9'd3}}, {L{12'd5}}, 0);
        wait_valid("unsat", -1);
        take_result("unsat");

        run_group(2, 0);
        wait_valid("bp", -1);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            din0 = (L*D0)'({$urandom, $urandom});
            din1 = (L*D1)'({$urandom, $urandom});
            tick;
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_data", lane_out(c % L), m_acc[c % L]);
        end
        in_valid = 1'b0;
        take_result("bp");

        for (int i = 0; i < NT; i++) send(1'b0, {L{9'd3}}, {L{12'hFFE}}, i % 2);
        wait_valid("gap", -1);
        chk("gap_model", m_acc[3], -96);
        take_result("gap");

        for (int i = 0; i < 7; i++) send(1'b1, (L*D0)'({$urandom, $urandom}), (L*D1)'({$urandom, $urandom}), 0);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_data", longint'(out_data == '0), 1);
        chk("rstmid_sat", out_sat, 0);
        chk("rstmid_ready", in_ready, 1);
        tick;
        ap_rst_n = 1'b1;
        model_clear;
        run_group(2, 1);
        wait_valid("post_rst", -1);
        take_result("post_rst");

        for (int i = 0; i < NT; i++) send(1'b0, {L{9'd100}}, {L{12'd7}}, 0);
        wait_valid("rsthold", -1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("rsthold_valid", out_valid, 0);
        chk("rsthold_data", longint'(out_data == '0), 1);
        tick;
        ap_rst_n = 1'b1;
        model_clear;

        for (int g = 0; g < 5; g++) begin
            run_group(2, 2);
            wait_valid("rnd", -1);
            take_result("rnd");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
